// File: rtl/mdu_iter.sv
// Iterative multiply/divide unit owning the architectural HI/LO pair.
// Define MDU_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops (codes 9-12).
module mdu_iter #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned MUL_CYCLES = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             busy,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CNT_MAX = (WIDTH > MUL_CYCLES) ? WIDTH : MUL_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;
`endif

    localparam logic [1:0] ACC_SET = 2'd0;
    localparam logic [1:0] ACC_ADD = 2'd1;
    localparam logic [1:0] ACC_SUB = 2'd2;

    logic [1:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [1:0]         acc_q, acc_d;
    logic [WIDTH-1:0]   quo_q, quo_d, dvs_q, dvs_d, rem_q, rem_d;
    logic               qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

    logic               sgn;
    logic [2*WIDTH-1:0] a_ext, b_ext, prod_new;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH:0]     shift_rem, trial;

    always_comb begin
        sgn = (op == OP_MULT) || (op == OP_DIV);
`ifdef MDU_MADD_EN
        sgn = sgn || (op == OP_MADD) || (op == OP_MSUB);
`endif
    end

    assign a_ext    = {{WIDTH{sgn & in_a[WIDTH-1]}}, in_a};
    assign b_ext    = {{WIDTH{sgn & in_b[WIDTH-1]}}, in_b};
    assign prod_new = a_ext * b_ext;
    assign a_mag    = (sgn && in_a[WIDTH-1]) ? -in_a : in_a;
    assign b_mag    = (sgn && in_b[WIDTH-1]) ? -in_b : in_b;

    // Restoring step: bit WIDTH of the trial difference is set when the subtract underflows.
    assign shift_rem = {rem_q, quo_q[WIDTH-1]};
    assign trial     = shift_rem - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        prod_d  = prod_q;
        acc_d   = acc_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        dz_d    = dz_q;
        case (state_q)
            S_IDLE: begin
                if (start && !req) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            prod_d  = prod_new;
                            acc_d   = ACC_SET;
                            cnt_d   = CW'(MUL_CYCLES - 1);
                            state_d = S_MUL;
                        end
`ifdef MDU_MADD_EN
                        OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                            prod_d  = prod_new;
                            acc_d   = (op == OP_MSUB || op == OP_MSUBU) ? ACC_SUB : ACC_ADD;
                            cnt_d   = CW'(MUL_CYCLES - 1);
                            state_d = S_MUL;
                        end
`endif
                        OP_DIV, OP_DIVU: begin
                            quo_d   = a_mag;
                            dvs_d   = b_mag;
                            rem_d   = '0;
                            qneg_d  = sgn & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
                            rneg_d  = sgn & in_a[WIDTH-1];
                            dz_d    = (in_b == '0);
                            cnt_d   = CW'(WIDTH);
                            state_d = S_DIV;
                        end
                        OP_MTHI: hi_d = in_a;
                        OP_MTLO: lo_d = in_a;
                        default: ;
                    endcase
                end
            end
            S_MUL: begin
                if (req) begin
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    // Accumulate against HI/LO as they stand at completion.
                    case (acc_q)
                        ACC_ADD: {hi_d, lo_d} = {hi_q, lo_q} + prod_q;
                        ACC_SUB: {hi_d, lo_d} = {hi_q, lo_q} - prod_q;
                        default: {hi_d, lo_d} = prod_q;
                    endcase
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            S_DIV: begin
                if (req || dz_q) begin
                    state_d = S_IDLE;
                end else if (cnt_q != '0) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = shift_rem[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    lo_d    = qneg_q ? -quo_q : quo_q;
                    hi_d    = rneg_q ? -rem_q : rem_q;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            prod_q  <= '0;
            acc_q   <= ACC_SET;
            quo_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            prod_q  <= prod_d;
            acc_q   <= acc_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            dz_q    <= dz_d;
        end
    end

    assign busy = (state_q != S_IDLE);
    assign hi   = hi_q;
    assign lo   = lo_q;

    always_comb begin
        case (op)
            OP_MFHI: result = hi_q;
            OP_MFLO: result = lo_q;
            default: result = '0;
        endcase
    end

endmodule

// File: tb/tb_mdu_iter.sv
// Self-checking bench for mdu_iter: randomized ops against an arithmetic HI/LO reference model.
// Exercises the MDU_MADD_EN accumulate ops when that macro is defined, otherwise checks they are NOPs.
module tb_mdu_iter;

    localparam int W  = 32;
    localparam int MC = 5;

    localparam logic [3:0] OP_NOP   = 4'd0;
    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
    localparam logic [3:0] OP_MFHI  = 4'd7;
    localparam logic [3:0] OP_MFLO  = 4'd8;
    localparam logic [3:0] OP_MADD  = 4'd9;
    localparam logic [3:0] OP_MADDU = 4'd10;
    localparam logic [3:0] OP_MSUB  = 4'd11;
    localparam logic [3:0] OP_MSUBU = 4'd12;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         req = 1'b0;
    logic         start = 1'b0;
    logic [3:0]   op = 4'd0;
    logic [W-1:0] in_a = '0;
    logic [W-1:0] in_b = '0;
    logic         busy;
    logic [W-1:0] result, hi, lo;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] ref_hi = '0;
    logic [W-1:0] ref_lo = '0;

    mdu_iter #(.WIDTH(W), .MUL_CYCLES(MC)) dut (
        .clk(clk), .reset(reset), .req(req), .start(start), .op(op),
        .in_a(in_a), .in_b(in_b), .busy(busy), .result(result), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reset && start && busy) begin
            errors++;
            $display("FAIL protocol: start=%b raised while busy=%b", start, busy);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b,
                                            input bit s);
        longint x, y;
        x = s ? longint'($signed(a)) : longint'({32'h0, a});
        y = s ? longint'($signed(b)) : longint'({32'h0, b});
        return 64'(x * y);
    endfunction

    // Updates the reference HI/LO and returns the expected number of busy cycles.
    function automatic int model_op(input logic [3:0] o, input logic [31:0] a,
                                    input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        case (o)
            OP_MULT, OP_MULTU: begin
                p = mul_ref(a, b, o == OP_MULT);
                {ref_hi, ref_lo} = p;
                return MC;
            end
            OP_DIV: begin
                if (b == 32'h0) return 1;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    ref_lo = a;
                    ref_hi = 32'h0;
                end else begin
                    sa = longint'($signed(a));
                    sb = longint'($signed(b));
                    ref_lo = 32'(sa / sb);
                    ref_hi = 32'(sa % sb);
                end
                return W + 1;
            end
            OP_DIVU: begin
                if (b == 32'h0) return 1;
                ref_lo = a / b;
                ref_hi = a % b;
                return W + 1;
            end
            OP_MTHI: begin ref_hi = a; return 0; end
            OP_MTLO: begin ref_lo = a; return 0; end
`ifdef MDU_MADD_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
                p = mul_ref(a, b, o == OP_MADD || o == OP_MSUB);
                if (o == OP_MADD || o == OP_MADDU) {ref_hi, ref_lo} = {ref_hi, ref_lo} + p;
                else {ref_hi, ref_lo} = {ref_hi, ref_lo} - p;
                return MC;
            end
`endif
            default: return 0;
        endcase
    endfunction

    // Presents one op for a single cycle; returns at the negedge after the accept edge.
    task automatic issue_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic r);
        @(negedge clk);
        start = 1'b1; op = o; in_a = a; in_b = b; req = r;
        @(negedge clk);
        start = 1'b0; op = OP_NOP; req = 1'b0;
    endtask

    task automatic exec_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int n);
        issue_op(o, a, b, 1'b0);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        op = OP_MFHI;
        #3;
        checks += 4;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        if (result !== 32'h0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        op = OP_NOP;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_mult();
        int n, ec;
        logic [31:0] a, b;
        logic [3:0] o;
        ec = model_op(OP_MULT, 32'hFFFF_FFFF, 32'h2);
        exec_op(OP_MULT, 32'hFFFF_FFFF, 32'h2, n);
        checks += 3;
        if (n !== 5) begin errors++; $display("FAIL mult_cycles: got %0d want 5", n); end
        if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL mult_lo: got %h want fffffffe", lo); end
        ec = model_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2);
        exec_op(OP_MULTU, 32'hFFFF_FFFF, 32'h2, n);
        checks += 2;
        if (hi !== 32'h1) begin errors++; $display("FAIL multu_hi: got %h want 00000001", hi); end
        if (lo !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_lo: got %h want fffffffe", lo); end
        for (int i = 0; i < 12; i++) begin
            o = (i % 2 == 0) ? OP_MULT : OP_MULTU;
            a = $urandom;
            b = $urandom;
            ec = model_op(o, a, b);
            exec_op(o, a, b, n);
            checks += 2;
            if (n !== ec) begin errors++; $display("FAIL mul_rand_cycles: op %0d got %0d want %0d", o, n, ec); end
            if (hi !== ref_hi || lo !== ref_lo)
                begin errors++; $display("FAIL mul_rand_hilo: op %0d a %h b %h got %h_%h want %h_%h", o, a, b, hi, lo, ref_hi, ref_lo); end
        end
    endtask

    task automatic test_div();
        int n, ec;
        logic [3:0]  dop [3] = '{OP_DIV, OP_DIVU, OP_DIV};
        logic [31:0] da [3] = '{32'hFFFF_FFF9, 32'h7, 32'h8000_0000};
        logic [31:0] db [3] = '{32'h2, 32'h2, 32'hFFFF_FFFF};
        logic [31:0] eh [3] = '{32'hFFFF_FFFF, 32'h1, 32'h0};
        logic [31:0] el [3] = '{32'hFFFF_FFFD, 32'h3, 32'h8000_0000};
        logic [31:0] a, b;
        logic [3:0] o;
        for (int i = 0; i < 3; i++) begin
            ec = model_op(dop[i], da[i], db[i]);
            exec_op(dop[i], da[i], db[i], n);
            checks += 3;
            if (n !== 33) begin errors++; $display("FAIL div_dir_cycles[%0d]: got %0d want 33", i, n); end
            if (hi !== eh[i]) begin errors++; $display("FAIL div_dir_hi[%0d]: got %h want %h", i, hi, eh[i]); end
            if (lo !== el[i]) begin errors++; $display("FAIL div_dir_lo[%0d]: got %h want %h", i, lo, el[i]); end
        end
        for (int i = 0; i < 12; i++) begin
            o = (i % 2 == 0) ? OP_DIV : OP_DIVU;
            a = $urandom;
            b = $urandom >> $urandom_range(31, 0);
            ec = model_op(o, a, b);
            exec_op(o, a, b, n);
            checks += 2;
            if (n !== ec) begin errors++; $display("FAIL div_rand_cycles: op %0d got %0d want %0d", o, n, ec); end
            if (hi !== ref_hi || lo !== ref_lo)
                begin errors++; $display("FAIL div_rand_hilo: op %0d a %h b %h got %h_%h want %h_%h", o, a, b, hi, lo, ref_hi, ref_lo); end
        end
    endtask

    task automatic test_mt_div0();
        int n, ec;
        ec = model_op(OP_MTHI, 32'h1234, 32'h0);
        exec_op(OP_MTHI, 32'h1234, 32'h0, n);
        checks++;
        if (n !== 0) begin errors++; $display("FAIL mthi_busy: got %0d want 0", n); end
        ec = model_op(OP_MTLO, 32'h5678, 32'h0);
        exec_op(OP_MTLO, 32'h5678, 32'h0, n);
        ec = model_op(OP_DIV, 32'h77, 32'h0);
        exec_op(OP_DIV, 32'h77, 32'h0, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL div0_cycles: got %0d want 1", n); end
        ec = model_op(OP_DIVU, 32'h99, 32'h0);
        exec_op(OP_DIVU, 32'h99, 32'h0, n);
        checks++;
        if (n !== 1) begin errors++; $display("FAIL divu0_cycles: got %0d want 1", n); end
        op = OP_MFHI;
        #1;
        checks++;
        if (result !== 32'h1234) begin errors++; $display("FAIL mfhi_after_div0: got %h want 00001234", result); end
        op = OP_MFLO;
        #1;
        checks++;
        if (result !== 32'h5678) begin errors++; $display("FAIL mflo_after_div0: got %h want 00005678", result); end
        op = OP_NOP;
    endtask

    task automatic test_flush();
        int n, ec;
        logic [31:0] a, b;
        ec = model_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0);
        exec_op(OP_MTHI, 32'hA5A5_A5A5, 32'h0, n);
        ec = model_op(OP_MTLO, 32'h5A5A_5A5A, 32'h0);
        exec_op(OP_MTLO, 32'h5A5A_5A5A, 32'h0, n);
        issue_op(OP_DIVU, 32'd100, 32'd7, 1'b0);
        repeat (9) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_div_busy: got %b want 0", busy); end
        if (hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL flush_div_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
        issue_op(OP_MULT, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        repeat (MC - 1) @(negedge clk);
        req = 1'b1;
        @(negedge clk);
        req = 1'b0;
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL flush_mul_last_busy: got %b want 0", busy); end
        if (hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL flush_mul_last_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
        issue_op(OP_MULT, 32'h3, 32'h4, 1'b1);
        checks += 2;
        if (busy !== 1'b0) begin errors++; $display("FAIL start_req_busy: got %b want 0", busy); end
        if (hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL start_req_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
        issue_op(OP_MTHI, 32'hDEAD_BEEF, 32'h0, 1'b1);
        issue_op(OP_MTLO, 32'hCAFE_F00D, 32'h0, 1'b1);
        checks++;
        if (hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL mt_req_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
        a = $urandom;
        b = $urandom >> 8;
        ec = model_op(OP_DIV, a, b);
        exec_op(OP_DIV, a, b, n);
        checks++;
        if (n !== ec || hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL div_after_flush: cycles %0d hilo %h_%h want %0d %h_%h", n, hi, lo, ec, ref_hi, ref_lo); end
    endtask

    task automatic test_reset_mid();
        int n, ec;
        logic [31:0] a, b;
        issue_op(OP_MULT, 32'h6, 32'h7, 1'b0);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        ref_hi = '0;
        ref_lo = '0;
        checks += 3;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_mid_busy: got %b want 0", busy); end
        if (hi !== 32'h0) begin errors++; $display("FAIL reset_mid_hi: got %h want 0", hi); end
        if (lo !== 32'h0) begin errors++; $display("FAIL reset_mid_lo: got %h want 0", lo); end
        @(negedge clk);
        reset = 1'b1;
        a = $urandom;
        b = $urandom;
        ec = model_op(OP_MULT, a, b);
        exec_op(OP_MULT, a, b, n);
        checks++;
        if (n !== ec || hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL mult_after_reset: cycles %0d hilo %h_%h want %0d %h_%h", n, hi, lo, ec, ref_hi, ref_lo); end
    endtask

    task automatic test_madd();
        int n, ec;
        logic [31:0] a, b;
        logic [3:0] o;
        ec = model_op(OP_MTHI, 32'h0, 32'h0);
        exec_op(OP_MTHI, 32'h0, 32'h0, n);
        ec = model_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0);
        exec_op(OP_MTLO, 32'hFFFF_FFFF, 32'h0, n);
`ifdef MDU_MADD_EN
        ec = model_op(OP_MADDU, 32'h1, 32'h1);
        exec_op(OP_MADDU, 32'h1, 32'h1, n);
        checks += 2;
        if (n !== 5) begin errors++; $display("FAIL maddu_cycles: got %0d want 5", n); end
        if (hi !== 32'h1 || lo !== 32'h0)
            begin errors++; $display("FAIL maddu_hilo: got %h_%h want 00000001_00000000", hi, lo); end
        ec = model_op(OP_MSUB, 32'h1, 32'h1);
        exec_op(OP_MSUB, 32'h1, 32'h1, n);
        checks++;
        if (hi !== 32'h0 || lo !== 32'hFFFF_FFFF)
            begin errors++; $display("FAIL msub_hilo: got %h_%h want 00000000_ffffffff", hi, lo); end
        for (int i = 0; i < 8; i++) begin
            o = OP_MADD + 4'(i % 4);
            a = $urandom;
            b = $urandom;
            ec = model_op(o, a, b);
            exec_op(o, a, b, n);
            checks++;
            if (n !== ec || hi !== ref_hi || lo !== ref_lo)
                begin errors++; $display("FAIL madd_rand: op %0d cycles %0d hilo %h_%h want %0d %h_%h", o, n, hi, lo, ec, ref_hi, ref_lo); end
        end
`else
        exec_op(OP_MADD, 32'h3, 32'h4, n);
        checks += 2;
        if (n !== 0) begin errors++; $display("FAIL madd_disabled_busy: got %0d want 0", n); end
        if (hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL madd_disabled_hilo: got %h_%h want %h_%h", hi, lo, ref_hi, ref_lo); end
`endif
        exec_op(4'd13, 32'h3, 32'h4, n);
        checks++;
        if (n !== 0 || hi !== ref_hi || lo !== ref_lo)
            begin errors++; $display("FAIL op13_nop: cycles %0d hilo %h_%h want 0 %h_%h", n, hi, lo, ref_hi, ref_lo); end
    endtask

    task automatic test_back_to_back();
        int n, ec;
        logic [31:0] a, b;
        logic [3:0] o;
        logic [3:0] mix [9] = '{OP_NOP, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU,
                                OP_MTHI, OP_MTLO, OP_MFHI, OP_MFLO};
        for (int i = 0; i < 24; i++) begin
            o = mix[$urandom_range(8, 0)];
            a = $urandom;
            b = ($urandom_range(5, 0) == 0) ? 32'h0 : ($urandom >> $urandom_range(31, 0));
            ec = model_op(o, a, b);
            exec_op(o, a, b, n);
            checks++;
            if (n !== ec || hi !== ref_hi || lo !== ref_lo)
                begin errors++; $display("FAIL mix[%0d]: op %0d a %h b %h cycles %0d hilo %h_%h want %0d %h_%h", i, o, a, b, n, hi, lo, ec, ref_hi, ref_lo); end
        end
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_mt_div0();
        test_flush();
        test_reset_mid();
        test_madd();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
